// File: rtl/imm_inst_encoder_pkg.sv
// imm_inst_encoder_pkg: format/opcode-class constants and signed-range helper; IMM_RANGE_CHK_EN enables range flags
package imm_inst_encoder_pkg;
  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_LI = 3'd6;
  localparam logic [4:0] OPC_LOAD = 5'b00000, OPC_OPIMM = 5'b00100, OPC_AUIPC = 5'b00101,
                         OPC_OPIMM32 = 5'b00110, OPC_STORE = 5'b01000, OPC_OP = 5'b01100,
                         OPC_LUI = 5'b01101, OPC_OP32 = 5'b01110, OPC_BRANCH = 5'b11000,
                         OPC_JALR = 5'b11001, OPC_JAL = 5'b11011, OPC_SYSTEM = 5'b11100;
`ifdef IMM_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif
  function automatic logic fits(input logic [63:0] v, input int unsigned n);
    logic [63:0] s;
    s = 64'($signed(v) >>> (n - 1));
    return s == '0 || s == '1;
  endfunction
endpackage

// File: rtl/imm_inst_encoder_if.sv
// imm_inst_encoder_if: request (in_*) and encoded-word (out_*) valid/ready bus; master = requester/consumer, slave = encoder
interface imm_inst_encoder_if #(parameter int XLEN = 64);
  logic in_valid, in_ready;
  logic [2:0] in_fmt, in_funct3;
  logic [4:0] in_opc, in_rd, in_rs1, in_rs2;
  logic [6:0] in_funct7;
  logic [XLEN-1:0] in_imm;
  logic out_valid, out_ready, out_last, out_err;
  logic [31:0] out_inst;
  modport master(output in_valid, in_fmt, in_opc, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
                 input in_ready, out_valid, out_inst, out_last, out_err);
  modport slave(input in_valid, in_fmt, in_opc, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
                output in_ready, out_valid, out_inst, out_last, out_err);
endinterface

// File: rtl/imm_inst_encoder_imm_field_pack.sv
// imm_field_pack: packs fmt/opc/regs/funct/imm into a 32-bit word; err flags out-of-range imm (IMM_RANGE_CHK_EN)
module imm_field_pack import imm_inst_encoder_pkg::*; #(
  parameter int XLEN = 64
) (
  input  logic [2:0]      fmt,
  input  logic [4:0]      opc,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] imm,
  output logic [31:0]     inst,
  output logic            err
);
  logic [63:0] v;
  logic [6:0] op;
  logic shift, rng;
  logic [11:0] iimm;
  always_comb begin
    v = 64'($signed(imm));
    op = {opc, 2'b11};
    shift = fmt == FMT_I && (opc == OPC_OPIMM || opc == OPC_OPIMM32) && funct3[1:0] == 2'b01;
    // shifts: RV64 OP-IMM carries funct6 over a 6-bit shamt, OP-IMM-32 funct7 over a 5-bit shamt
    iimm = !shift ? imm[11:0] : opc == OPC_OPIMM ? {funct7[6:1], imm[5:0]} : {funct7, imm[4:0]};
    inst = fmt == FMT_R ? {funct7, rs2, rs1, funct3, rd, op} :
           fmt == FMT_I ? {iimm, rs1, funct3, rd, op} :
           fmt == FMT_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], op} :
           fmt == FMT_B ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op} :
           fmt == FMT_U ? {imm[31:12], rd, op} :
           fmt == FMT_J ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, op} : {25'b0, op};
    rng = fmt == FMT_I || fmt == FMT_S ? !fits(v, 12) :
          fmt == FMT_B ? !fits(v, 13) || imm[0] :
          fmt == FMT_J ? !fits(v, 21) || imm[0] :
          fmt == FMT_U ? |imm[11:0] || !fits(v, 32) : 1'b0;
  end
  assign err = RANGE_CHK && rng;
endmodule

// File: rtl/imm_inst_encoder.sv
// imm_inst_encoder: streams RV64I words from decoded fields, expanding LI into LUI+ADDIW
// ports: clk, rst_n (async active-low), bus (imm_inst_encoder_if.slave); IMM_RANGE_CHK_EN drives out_err
module imm_inst_encoder import imm_inst_encoder_pkg::*; #(
  parameter int XLEN     = 64,
  parameter bit LI_SHORT = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  imm_inst_encoder_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0, S_LI2 = 1'b1;
  logic [0:0] st;
  logic [4:0] lrd, p_opc, p_rd, p_rs1;
  logic [11:0] llo;
  logic [19:0] hi20;
  logic [2:0] p_fmt, p_f3;
  logic [XLEN-1:0] p_imm;
  logic [31:0] p_inst;
  logic is_li, short_li, li2, li_err, pk_err, accept;
  always_comb begin
    // +0x800 pre-rounds so the sign-extended ADDIW lo12 lands back on the constant
    hi20 = 20'((bus.in_imm[31:0] + 32'h800) >> 12);
    is_li = bus.in_fmt == FMT_LI;
    short_li = LI_SHORT && hi20 == 20'd0;
    li2 = st == S_LI2;
    li_err = RANGE_CHK && !fits(64'($signed(bus.in_imm)), 32);
    accept = bus.in_valid && bus.in_ready;
    p_fmt = li2 || (is_li && short_li) ? FMT_I : is_li ? FMT_U : bus.in_fmt;
    p_opc = li2 || (is_li && short_li) ? OPC_OPIMM32 : is_li ? OPC_LUI : bus.in_opc;
    p_rd = li2 ? lrd : bus.in_rd;
    p_rs1 = li2 ? lrd : is_li ? 5'd0 : bus.in_rs1;
    p_f3 = li2 || is_li ? 3'd0 : bus.in_funct3;
    p_imm = li2 ? XLEN'($signed(llo)) :
            !is_li ? bus.in_imm :
            short_li ? XLEN'($signed(bus.in_imm[11:0])) : XLEN'($signed({hi20, 12'b0}));
  end
  assign bus.in_ready = !li2 && (!bus.out_valid || bus.out_ready);
  imm_field_pack #(.XLEN(XLEN)) u_pack (
    .fmt(p_fmt), .opc(p_opc), .rd(p_rd), .rs1(p_rs1), .rs2(bus.in_rs2), .funct3(p_f3),
    .funct7(bus.in_funct7), .imm(p_imm), .inst(p_inst), .err(pk_err)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_IDLE;
      lrd <= '0;
      llo <= '0;
      bus.out_valid <= 1'b0;
      bus.out_inst <= '0;
      bus.out_last <= 1'b0;
      bus.out_err <= 1'b0;
    end else if (li2) begin
      // LUI word is still presented; out_err already carries the LI flag for both words
      if (bus.out_ready) begin
        bus.out_inst <= p_inst;
        bus.out_last <= 1'b1;
        st <= S_IDLE;
      end
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_inst <= p_inst;
      bus.out_last <= !is_li || short_li;
      bus.out_err <= is_li ? li_err : pk_err;
      if (is_li && !short_li) begin
        st <= S_LI2;
        lrd <= bus.in_rd;
        llo <= bus.in_imm[11:0];
      end
    end else if (bus.out_ready) bus.out_valid <= 1'b0;
endmodule

// File: tb/tb_imm_inst_encoder.sv
// tb_imm_inst_encoder: scoreboard bench for imm_inst_encoder
module tb_imm_inst_encoder;
  import imm_inst_encoder_pkg::*;
`ifdef IMM_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct packed {
    logic [2:0] fmt;
    logic [4:0] opc, rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [63:0] imm;
  } req_t;
  typedef struct packed {
    logic [31:0] inst;
    logic last, err;
  } exp_t;
  logic clk, rst_n;
  int checks, failures, w;
  bit rnd_rdy;
  exp_t q[$];
  exp_t e;
  logic pv, pr, plast, perr;
  logic [31:0] pinst;
  req_t r;
  imm_inst_encoder_if #(.XLEN(64)) bus();
  imm_inst_encoder #(.XLEN(64), .LI_SHORT(1'b1)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic req_t mk(input logic [2:0] fmt, input logic [4:0] opc, rd, rs1, rs2,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] imm);
    return '{fmt, opc, rd, rs1, rs2, f3, f7, imm};
  endfunction
  function automatic logic [31:0] pack(input req_t x);
    logic [6:0] op;
    logic [11:0] ii;
    op = {x.opc, 2'b11};
    ii = x.imm[11:0];
    if (x.fmt == FMT_I && x.f3[1:0] == 2'b01 && x.opc == 5'b00100) ii = {x.f7[6:1], x.imm[5:0]};
    if (x.fmt == FMT_I && x.f3[1:0] == 2'b01 && x.opc == 5'b00110) ii = {x.f7, x.imm[4:0]};
    case (x.fmt)
      FMT_R: return {x.f7, x.rs2, x.rs1, x.f3, x.rd, op};
      FMT_I: return {ii, x.rs1, x.f3, x.rd, op};
      FMT_S: return {x.imm[11:5], x.rs2, x.rs1, x.f3, x.imm[4:0], op};
      FMT_B: return {x.imm[12], x.imm[10:5], x.rs2, x.rs1, x.f3, x.imm[4:1], x.imm[11], op};
      FMT_U: return {x.imm[31:12], x.rd, op};
      FMT_J: return {x.imm[20], x.imm[10:1], x.imm[11], x.imm[19:12], x.rd, op};
      default: return {25'b0, op};
    endcase
  endfunction
  function automatic logic bad(input req_t x);
    logic signed [63:0] s;
    s = x.imm;
    case (x.fmt)
      FMT_I, FMT_S: return s < -64'sd2048 || s > 64'sd2047;
      FMT_B: return s < -64'sd4096 || s > 64'sd4095 || x.imm[0];
      FMT_J: return s < -64'sd1048576 || s > 64'sd1048575 || x.imm[0];
      FMT_U: return x.imm[11:0] != 12'd0 || s < -64'sd2147483648 || s > 64'sd2147483647;
      FMT_LI: return s < -64'sd2147483648 || s > 64'sd2147483647;
      default: return 1'b0;
    endcase
  endfunction
  task automatic push_exp(input logic [31:0] inst, input logic last, input logic err);
    q.push_back({inst, last, err});
  endtask
  task automatic push_req(input req_t x);
    logic signed [63:0] t;
    logic [19:0] hi;
    logic er;
    er = CHK && bad(x);
    t = ($signed({{32{x.imm[31]}}, x.imm[31:0]}) + 64'sd2048) >>> 12;
    hi = t[19:0];
    if (x.fmt != FMT_LI) push_exp(pack(x), 1'b1, er);
    else if (hi == 20'd0) push_exp({x.imm[11:0], 5'd0, 3'b000, x.rd, 7'b0011011}, 1'b1, er);
    else begin
      push_exp({hi, x.rd, 7'b0110111}, 1'b0, er);
      push_exp({x.imm[11:0], x.rd, 3'b000, x.rd, 7'b0011011}, 1'b1, er);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic drive(input req_t x, output int waits);
    bus.in_fmt = x.fmt;
    bus.in_opc = x.opc;
    bus.in_rd = x.rd;
    bus.in_rs1 = x.rs1;
    bus.in_rs2 = x.rs2;
    bus.in_funct3 = x.f3;
    bus.in_funct7 = x.f7;
    bus.in_imm = x.imm;
    bus.in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 200) begin
        chk("accept_timeout", 1, 0);
        break;
      end
      tick();
    end
    tick();
  endtask
  task automatic send(input req_t x);
    int wt;
    push_req(x);
    drive(x, wt);
  endtask
  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    chk("drain", q.size(), 0);
  endtask
  always @(negedge clk) begin
    if (!rst_n) pv = 1'b0;
    else begin
      if (pv && !pr) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_inst", bus.out_inst, pinst);
        chk("hold_last", bus.out_last, plast);
        chk("hold_err", bus.out_err, perr);
      end
      if (bus.out_valid && !bus.out_last) chk("li_in_ready", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("unexpected_beat", bus.out_inst, 0);
        else begin
          e = q.pop_front();
          chk("inst", bus.out_inst, e.inst);
          chk("last", bus.out_last, e.last);
          chk("err", bus.out_err, e.err);
        end
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      pinst = bus.out_inst;
      plast = bus.out_last;
      perr = bus.out_err;
    end
  end
  initial begin
    checks = 0;
    failures = 0;
    rnd_rdy = 1'b0;
    rst_n = 1'b0;
    r = '0;
    bus.in_valid = 1'b0;
    bus.in_fmt = '0;
    bus.in_opc = '0;
    bus.in_rd = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_funct3 = '0;
    bus.in_funct7 = '0;
    bus.in_imm = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_inst", bus.out_inst, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    tick();
    push_exp(32'hFFF00093, 1'b1, 1'b0);
    drive(mk(FMT_I, OPC_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd1), w);
    push_exp(32'h123452B7, 1'b0, 1'b0);
    push_exp(32'h6782829B, 1'b1, 1'b0);
    drive(mk(FMT_LI, 5'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345678), w);
    push_exp(32'h001000EF, 1'b1, 1'b0);
    drive(mk(FMT_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048), w);
    push_exp(32'h80000093, 1'b1, CHK);
    drive(mk(FMT_I, OPC_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048), w);
    push_exp(32'h800002B7, 1'b0, 1'b0);
    push_exp(32'h8002829B, 1'b1, 1'b0);
    drive(mk(FMT_LI, 5'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h7FFFF800), w);
    push_exp(32'h0050019B, 1'b1, 1'b0);
    drive(mk(FMT_LI, 5'd0, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5), w);
    send(mk(FMT_LI, 5'd0, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1_0000_0000));
    drain();
    bus.out_ready = 1'b0;
    send(mk(FMT_LI, 5'd0, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 64'h0ABCD123));
    bus.in_valid = 1'b0;
    repeat (5) tick();
    drain();
    for (int i = 0; i < 8; i++) begin
      r = mk(FMT_I, OPC_OPIMM, 5'(i + 1), 5'(i), 5'd0, 3'd0, 7'd0, 64'(i * 3));
      push_req(r);
      drive(r, w);
      chk("burst_stall", w, 0);
    end
    drain();
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      r.fmt = 3'($urandom_range(0, 6));
      r.opc = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? OPC_OPIMM : OPC_OPIMM32) : 5'($urandom);
      r.rd = 5'($urandom);
      r.rs1 = 5'($urandom);
      r.rs2 = 5'($urandom);
      r.f3 = 3'($urandom);
      r.f7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0: r.imm = {$urandom, $urandom};
        1: r.imm = 64'($signed(12'($urandom)));
        2: r.imm = 64'($signed(21'($urandom)));
        default: r.imm = 64'($signed(32'($urandom)));
      endcase
      send(r);
    end
    rnd_rdy = 1'b0;
    drain();
    bus.out_ready = 1'b0;
    drive(mk(FMT_LI, 5'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345678), w);
    bus.in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_in_ready", bus.in_ready, 1);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_valid", bus.out_valid, 0);
    end
    chk("post_rst_in_ready", bus.in_ready, 1);
    tick();
    send(mk(FMT_S, OPC_STORE, 5'd0, 5'd2, 5'd8, 3'd3, 7'd0, -64'sd16));
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
